// File: rtl/lieat_exu_com_csrfile_pkg.sv
// Shared CSR address map, mstatus layout and reset constant for the M-mode CSR file.
// Counter addresses are only decoded when LIEAT_CSR_COUNTERS_EN is defined.
package lieat_exu_com_csrfile_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;

  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  // MPP hardwired to 2'b11 (machine mode only); MIE/MPIE clear.
  localparam logic [31:0] MSTATUS_RST = 32'h0000_1800;

  typedef struct packed {
    logic mpie;
    logic mie;
  } mstatus_t;

  function automatic logic [31:0] mstatus_pack(input mstatus_t st);
    logic [31:0] v;
    v = MSTATUS_RST;
    v[MSTATUS_MIE_BIT]  = st.mie;
    v[MSTATUS_MPIE_BIT] = st.mpie;
    return v;
  endfunction

endpackage

// File: rtl/lieat_exu_com_csrfile_if.sv
// CSR command/response bundle between the EXU CSR stage (master) and the CSR file (slave).
interface lieat_exu_com_csrfile_if #(
  parameter int XLEN    = 32,
  parameter int CSR_IDX = 12
);
  logic               csr_ena;
  logic               csr_write;
  logic               csr_read;
  logic [CSR_IDX-1:0] csr_idx;
  logic [XLEN-1:0]    csr_wdata;
  logic [CSR_IDX-1:0] csr_idx2;
  logic [XLEN-1:0]    csr_wdata2;
  logic               csr_retire;
  logic               csr_mret;
  logic [XLEN-1:0]    csr_rdata;
  logic               csr_illegal;

  modport master (
    output csr_ena, csr_write, csr_read, csr_idx, csr_wdata,
           csr_idx2, csr_wdata2, csr_retire, csr_mret,
    input  csr_rdata, csr_illegal
  );

  modport slave (
    input  csr_ena, csr_write, csr_read, csr_idx, csr_wdata,
           csr_idx2, csr_wdata2, csr_retire, csr_mret,
    output csr_rdata, csr_illegal
  );
endinterface

// File: rtl/lieat_csr_cnt64.sv
// 64-bit counter with per-half write; any write suppresses the increment for that cycle,
// so a low-half carry can never reach a high half that is being written.
module lieat_csr_cnt64 (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        inc_en,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] cnt
);

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      cnt <= 64'd0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) cnt[31:0]  <= wdata;
      if (wr_hi) cnt[63:32] <= wdata;
    end else if (inc_en) begin
      cnt <= cnt + 64'd1;
    end
  end

endmodule

// File: rtl/lieat_exu_com_csrfile.sv
// Machine-mode CSR file: trap state, ID registers and (with LIEAT_CSR_COUNTERS_EN defined)
// the mcycle/minstret counters plus their user-level read-only aliases.
module lieat_exu_com_csrfile
  import lieat_exu_com_csrfile_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter int          CSR_IDX     = 12,
  parameter logic [31:0] MTVEC_RST   = 32'h8000_0000,
  parameter logic [31:0] MARCHID_VAL = 32'h0,
  parameter logic [31:0] MHARTID_VAL = 32'h0
) (
  input  logic                       clock,
  input  logic                       rst_n,
  lieat_exu_com_csrfile_if.slave     csr,
  output logic [XLEN-1:0]            csr_mtvec,
  output logic [XLEN-1:0]            csr_mepc,
  output logic                       csr_mstatus_mie
);

  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mscratch_q;
  mstatus_t        mstatus_q;

  logic            hit;
  logic [XLEN-1:0] rval;
  logic            wr_en;
  logic            trap;

`ifdef LIEAT_CSR_COUNTERS_EN
  logic [63:0] mcycle;
  logic [63:0] minstret;

  lieat_csr_cnt64 u_mcycle (
    .clock  (clock),
    .rst_n  (rst_n),
    .inc_en (1'b1),
    .wr_lo  (wr_en && (csr.csr_idx == CSR_MCYCLE)),
    .wr_hi  (wr_en && (csr.csr_idx == CSR_MCYCLEH)),
    .wdata  (csr.csr_wdata[31:0]),
    .cnt    (mcycle)
  );

  lieat_csr_cnt64 u_minstret (
    .clock  (clock),
    .rst_n  (rst_n),
    .inc_en (csr.csr_retire),
    .wr_lo  (wr_en && (csr.csr_idx == CSR_MINSTRET)),
    .wr_hi  (wr_en && (csr.csr_idx == CSR_MINSTRETH)),
    .wdata  (csr.csr_wdata[31:0]),
    .cnt    (minstret)
  );
`else
  logic unused_retire;
  assign unused_retire = csr.csr_retire;
`endif

  always_comb begin
    hit  = 1'b0;
    rval = '0;
    case (csr.csr_idx)
      CSR_MSTATUS:  begin hit = 1'b1; rval = mstatus_pack(mstatus_q); end
      CSR_MTVEC:    begin hit = 1'b1; rval = mtvec_q;                 end
      CSR_MSCRATCH: begin hit = 1'b1; rval = mscratch_q;              end
      CSR_MEPC:     begin hit = 1'b1; rval = mepc_q;                  end
      CSR_MCAUSE:   begin hit = 1'b1; rval = mcause_q;                end
      CSR_MVENDORID,
      CSR_MIMPID:   begin hit = 1'b1; rval = '0;                      end
      CSR_MARCHID:  begin hit = 1'b1; rval = MARCHID_VAL;             end
      CSR_MHARTID:  begin hit = 1'b1; rval = MHARTID_VAL;             end
`ifdef LIEAT_CSR_COUNTERS_EN
      CSR_MCYCLE,
      CSR_CYCLE:     begin hit = 1'b1; rval = mcycle[31:0];    end
      CSR_MCYCLEH,
      CSR_CYCLEH:    begin hit = 1'b1; rval = mcycle[63:32];   end
      CSR_MINSTRET,
      CSR_INSTRET:   begin hit = 1'b1; rval = minstret[31:0];  end
      CSR_MINSTRETH,
      CSR_INSTRETH:  begin hit = 1'b1; rval = minstret[63:32]; end
`endif
      default: ;
    endcase
  end

  assign csr.csr_illegal = csr.csr_ena && !hit;
  assign csr.csr_rdata   = (csr.csr_ena && csr.csr_read && hit) ? rval : '0;

  // Read-only IDs and aliases decode as hits but have no write enable below.
  assign wr_en = csr.csr_ena && csr.csr_write && hit;
  assign trap  = csr.csr_ena && (csr.csr_idx2 == CSR_MCAUSE);

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      mtvec_q        <= MTVEC_RST;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mscratch_q     <= '0;
      mstatus_q.mie  <= 1'b0;
      mstatus_q.mpie <= 1'b0;
    end else begin
      if (wr_en && (csr.csr_idx == CSR_MTVEC))
        mtvec_q <= {csr.csr_wdata[XLEN-1:2], 2'b00};
      if (wr_en && (csr.csr_idx == CSR_MEPC))
        mepc_q <= {csr.csr_wdata[XLEN-1:2], 2'b00};
      if (wr_en && (csr.csr_idx == CSR_MSCRATCH))
        mscratch_q <= csr.csr_wdata;

      if (trap)
        mcause_q <= csr.csr_wdata2;
      else if (wr_en && (csr.csr_idx == CSR_MCAUSE))
        mcause_q <= csr.csr_wdata;

      // Trap entry beats mret, which beats a software mstatus write.
      if (trap) begin
        mstatus_q.mpie <= mstatus_q.mie;
        mstatus_q.mie  <= 1'b0;
      end else if (csr.csr_mret) begin
        mstatus_q.mie  <= mstatus_q.mpie;
        mstatus_q.mpie <= 1'b1;
      end else if (wr_en && (csr.csr_idx == CSR_MSTATUS)) begin
        mstatus_q.mie  <= csr.csr_wdata[MSTATUS_MIE_BIT];
        mstatus_q.mpie <= csr.csr_wdata[MSTATUS_MPIE_BIT];
      end
    end
  end

  assign csr_mtvec       = mtvec_q;
  assign csr_mepc        = mepc_q;
  assign csr_mstatus_mie = mstatus_q.mie;

endmodule

// File: tb/tb_lieat_exu_com_csrfile.sv
// Directed bench for the M-mode CSR file; counter checks follow LIEAT_CSR_COUNTERS_EN.
module tb_lieat_exu_com_csrfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        mie;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  lieat_exu_com_csrfile_if #(.XLEN(32), .CSR_IDX(12)) bus ();

  lieat_exu_com_csrfile #(
    .XLEN(32), .CSR_IDX(12), .MTVEC_RST(32'h8000_0000),
    .MARCHID_VAL(32'h0), .MHARTID_VAL(32'h0)
  ) dut (
    .clock           (clk),
    .rst_n           (rst_n),
    .csr             (bus),
    .csr_mtvec       (mtvec),
    .csr_mepc        (mepc),
    .csr_mstatus_mie (mie)
  );

  task automatic idle();
    bus.csr_ena    = 1'b0;
    bus.csr_write  = 1'b0;
    bus.csr_read   = 1'b0;
    bus.csr_idx    = 12'h0;
    bus.csr_wdata  = 32'h0;
    bus.csr_idx2   = 12'h0;
    bus.csr_wdata2 = 32'h0;
    bus.csr_retire = 1'b0;
    bus.csr_mret   = 1'b0;
  endtask

  task automatic set_cmd(input logic w, input logic r, input logic [11:0] idx,
                         input logic [31:0] wd, input logic [11:0] idx2, input logic [31:0] wd2);
    bus.csr_ena    = 1'b1;
    bus.csr_write  = w;
    bus.csr_read   = r;
    bus.csr_idx    = idx;
    bus.csr_wdata  = wd;
    bus.csr_idx2   = idx2;
    bus.csr_wdata2 = wd2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    set_cmd(1, 0, 12'h340, 32'hDEAD_BEEF, 12'h0, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_cmd(0, 1, 12'h300, 32'h0, 12'h0, 32'h0);
    #1;
    n_tests++; if (bus.csr_rdata !== 32'h0000_1800) begin n_fail++; $display("FAIL reset_mstatus got %h exp %h", bus.csr_rdata, 32'h0000_1800); end
    n_tests++; if (mtvec !== 32'h8000_0000) begin n_fail++; $display("FAIL reset_mtvec_out got %h exp %h", mtvec, 32'h8000_0000); end
    n_tests++; if (mie !== 1'b0) begin n_fail++; $display("FAIL reset_mie got %b exp 0", mie); end
    n_tests++; if (mepc !== 32'h0) begin n_fail++; $display("FAIL reset_mepc got %h exp 0", mepc); end
    @(negedge clk);
    set_cmd(0, 1, 12'h305, 32'h0, 12'h0, 32'h0);
    #1;
    n_tests++; if (bus.csr_rdata !== 32'h8000_0000) begin n_fail++; $display("FAIL reset_mtvec_rd got %h exp %h", bus.csr_rdata, 32'h8000_0000); end
    @(negedge clk);
    set_cmd(0, 1, 12'h340, 32'h0, 12'h0, 32'h0);
    #1;
    n_tests++; if (bus.csr_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_write_dropped got %h exp 0", bus.csr_rdata); end
  endtask

  task automatic test_mtvec_write();
    @(negedge clk);
    set_cmd(1, 1, 12'h305, 32'h1234_5677, 12'h0, 32'h0);
    #1;
    n_tests++; if (bus.csr_rdata !== 32'h8000_0000) begin n_fail++; $display("FAIL mtvec_read_old got %h exp %h", bus.csr_rdata, 32'h8000_0000); end
    @(negedge clk);
    set_cmd(0, 1, 12'h305, 32'h0, 12'h0, 32'h0);
    #1;
    n_tests++; if (mtvec !== 32'h1234_5674) begin n_fail++; $display("FAIL mtvec_warl got %h exp %h", mtvec, 32'h1234_5674); end
    n_tests++; if (bus.csr_rdata !== 32'h1234_5674) begin n_fail++; $display("FAIL mtvec_rd_new got %h exp %h", bus.csr_rdata, 32'h1234_5674); end
  endtask

  task automatic test_mstatus_warl();
    @(negedge clk);
    set_cmd(1, 0, 12'h300, 32'hFFFF_FFFF, 12'h0, 32'h0);
    @(negedge clk);
    set_cmd(0, 1, 12'h300, 32'h0, 12'h0, 32'h0);
    #1;
    n_tests++; if (bus.csr_rdata !== 32'h0000_1888) begin n_fail++; $display("FAIL mstatus_all_ones got %h exp %h", bus.csr_rdata, 32'h0000_1888); end
    n_tests++; if (mie !== 1'b1) begin n_fail++; $display("FAIL mstatus_mie_set got %b exp 1", mie); end
    @(negedge clk);
    set_cmd(1, 0, 12'h300, 32'h0, 12'h0, 32'h0);
    @(negedge clk);
    set_cmd(0, 1, 12'h300, 32'h0, 12'h0, 32'h0);
    #1;
    n_tests++; if (bus.csr_rdata !== 32'h0000_1800) begin n_fail++; $display("FAIL mstatus_zero got %h exp %h", bus.csr_rdata, 32'h0000_1800); end
    @(negedge clk);
    set_cmd(1, 0, 12'h300, 32'h0000_0008, 12'h0, 32'h0);
    @(negedge clk);
    idle();
  endtask

  task automatic test_ecall_mret();
    @(negedge clk);
    set_cmd(1, 0, 12'h341, 32'h8000_0104, 12'h342, 32'h1);
    @(negedge clk);
    set_cmd(0, 1, 12'h342, 32'h0, 12'h0, 32'h0);
    #1;
    n_tests++; if (bus.csr_rdata !== 32'h1) begin n_fail++; $display("FAIL ecall_mcause got %h exp 1", bus.csr_rdata); end
    n_tests++; if (mepc !== 32'h8000_0104) begin n_fail++; $display("FAIL ecall_mepc got %h exp %h", mepc, 32'h8000_0104); end
    n_tests++; if (mie !== 1'b0) begin n_fail++; $display("FAIL ecall_mie got %b exp 0", mie); end
    @(negedge clk);
    set_cmd(0, 1, 12'h300, 32'h0, 12'h0, 32'h0);
    #1;
    n_tests++; if (bus.csr_rdata !== 32'h0000_1880) begin n_fail++; $display("FAIL ecall_mstatus got %h exp %h", bus.csr_rdata, 32'h0000_1880); end
    @(negedge clk);
    idle();
    bus.csr_mret = 1'b1;
    @(negedge clk);
    bus.csr_mret = 1'b0;
    set_cmd(0, 1, 12'h300, 32'h0, 12'h0, 32'h0);
    #1;
    n_tests++; if (mie !== 1'b1) begin n_fail++; $display("FAIL mret_mie got %b exp 1", mie); end
    n_tests++; if (bus.csr_rdata !== 32'h0000_1888) begin n_fail++; $display("FAIL mret_mstatus got %h exp %h", bus.csr_rdata, 32'h0000_1888); end
  endtask

  task automatic test_priority();
    @(negedge clk);
    set_cmd(1, 0, 12'h300, 32'h0, 12'h0, 32'h0);
    bus.csr_mret = 1'b1;
    @(negedge clk);
    bus.csr_mret = 1'b0;
    set_cmd(0, 1, 12'h300, 32'h0, 12'h0, 32'h0);
    #1;
    n_tests++; if (bus.csr_rdata !== 32'h0000_1888) begin n_fail++; $display("FAIL mret_over_write got %h exp %h", bus.csr_rdata, 32'h0000_1888); end
    @(negedge clk);
    set_cmd(0, 0, 12'h300, 32'h0, 12'h342, 32'h0000_000B);
    bus.csr_mret = 1'b1;
    @(negedge clk);
    bus.csr_mret = 1'b0;
    set_cmd(0, 1, 12'h300, 32'h0, 12'h0, 32'h0);
    #1;
    n_tests++; if (bus.csr_rdata !== 32'h0000_1880) begin n_fail++; $display("FAIL trap_over_mret got %h exp %h", bus.csr_rdata, 32'h0000_1880); end
    @(negedge clk);
    set_cmd(0, 1, 12'h342, 32'h0, 12'h0, 32'h0);
    #1;
    n_tests++; if (bus.csr_rdata !== 32'h0000_000B) begin n_fail++; $display("FAIL trap_mcause got %h exp %h", bus.csr_rdata, 32'h0000_000B); end
  endtask

  task automatic test_collision();
    @(negedge clk);
    set_cmd(1, 0, 12'h342, 32'h5, 12'h342, 32'h1);
    @(negedge clk);
    set_cmd(0, 1, 12'h342, 32'h0, 12'h0, 32'h0);
    #1;
    n_tests++; if (bus.csr_rdata !== 32'h1) begin n_fail++; $display("FAIL collision_mcause got %h exp 1", bus.csr_rdata); end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    set_cmd(1, 1, 12'h7C0, 32'h55, 12'h0, 32'h0);
    #1;
    n_tests++; if (bus.csr_illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_flag got %b exp 1", bus.csr_illegal); end
    n_tests++; if (bus.csr_rdata !== 32'h0) begin n_fail++; $display("FAIL illegal_rdata got %h exp 0", bus.csr_rdata); end
    @(negedge clk);
    set_cmd(1, 1, 12'hF14, 32'h123, 12'h0, 32'h0);
    #1;
    n_tests++; if (bus.csr_illegal !== 1'b0) begin n_fail++; $display("FAIL ro_write_illegal got %b exp 0", bus.csr_illegal); end
    n_tests++; if (bus.csr_rdata !== 32'h0) begin n_fail++; $display("FAIL ro_mhartid got %h exp 0", bus.csr_rdata); end
    @(negedge clk);
    set_cmd(0, 0, 12'h300, 32'h0, 12'h341, 32'h40);
    @(negedge clk);
    set_cmd(0, 1, 12'h341, 32'h0, 12'h0, 32'h0);
    #1;
    n_tests++; if (bus.csr_rdata !== 32'h8000_0104) begin n_fail++; $display("FAIL idx2_ignored got %h exp %h", bus.csr_rdata, 32'h8000_0104); end
    n_tests++; if (mtvec !== 32'h1234_5674) begin n_fail++; $display("FAIL illegal_no_change got %h exp %h", mtvec, 32'h1234_5674); end
    @(negedge clk);
    idle();
    bus.csr_idx = 12'h7C0;
    #1;
    n_tests++; if (bus.csr_illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_no_ena got %b exp 0", bus.csr_illegal); end
    @(negedge clk);
    set_cmd(0, 0, 12'h305, 32'h0, 12'h0, 32'h0);
    #1;
    n_tests++; if (bus.csr_rdata !== 32'h0) begin n_fail++; $display("FAIL rdata_no_read got %h exp 0", bus.csr_rdata); end
  endtask

  task automatic test_scratch_mepc();
    @(negedge clk);
    set_cmd(1, 0, 12'h340, 32'hA5A5_5A5A, 12'h0, 32'h0);
    @(negedge clk);
    set_cmd(1, 1, 12'h341, 32'h0000_0003, 12'h0, 32'h0);
    @(negedge clk);
    set_cmd(0, 1, 12'h340, 32'h0, 12'h0, 32'h0);
    #1;
    n_tests++; if (bus.csr_rdata !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL mscratch got %h exp %h", bus.csr_rdata, 32'hA5A5_5A5A); end
    n_tests++; if (mepc !== 32'h0) begin n_fail++; $display("FAIL mepc_warl got %h exp 0", mepc); end
  endtask

  task automatic test_counters();
`ifdef LIEAT_CSR_COUNTERS_EN
    @(negedge clk);
    set_cmd(1, 0, 12'hB00, 32'hFFFF_FFFF, 12'h0, 32'h0);
    @(negedge clk);
    idle();
    @(negedge clk);
    set_cmd(0, 1, 12'hB00, 32'h0, 12'h0, 32'h0);
    #1;
    n_tests++; if (bus.csr_rdata !== 32'h0) begin n_fail++; $display("FAIL mcycle_wrap got %h exp 0", bus.csr_rdata); end
    @(negedge clk);
    set_cmd(0, 1, 12'hB80, 32'h0, 12'h0, 32'h0);
    #1;
    n_tests++; if (bus.csr_rdata !== 32'h1) begin n_fail++; $display("FAIL mcycleh_carry got %h exp 1", bus.csr_rdata); end
    @(negedge clk);
    idle();
    bus.csr_retire = 1'b1;
    repeat (3) @(negedge clk);
    bus.csr_retire = 1'b0;
    set_cmd(0, 1, 12'hC02, 32'h0, 12'h0, 32'h0);
    #1;
    n_tests++; if (bus.csr_rdata !== 32'h3) begin n_fail++; $display("FAIL minstret_count got %h exp 3", bus.csr_rdata); end
    @(negedge clk);
    set_cmd(1, 0, 12'hB02, 32'h10, 12'h0, 32'h0);
    bus.csr_retire = 1'b1;
    @(negedge clk);
    bus.csr_retire = 1'b0;
    set_cmd(0, 1, 12'hB02, 32'h0, 12'h0, 32'h0);
    #1;
    n_tests++; if (bus.csr_rdata !== 32'h10) begin n_fail++; $display("FAIL minstret_write_wins got %h exp %h", bus.csr_rdata, 32'h10); end
`else
    @(negedge clk);
    set_cmd(0, 1, 12'hB00, 32'h0, 12'h0, 32'h0);
    #1;
    n_tests++; if (bus.csr_illegal !== 1'b1) begin n_fail++; $display("FAIL mcycle_absent_illegal got %b exp 1", bus.csr_illegal); end
    n_tests++; if (bus.csr_rdata !== 32'h0) begin n_fail++; $display("FAIL mcycle_absent_rdata got %h exp 0", bus.csr_rdata); end
    @(negedge clk);
    set_cmd(0, 1, 12'hC82, 32'h0, 12'h0, 32'h0);
    #1;
    n_tests++; if (bus.csr_illegal !== 1'b1) begin n_fail++; $display("FAIL instreth_absent_illegal got %b exp 1", bus.csr_illegal); end
`endif
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_cmd(1, 0, 12'h340, 32'h1111_1111, 12'h0, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_cmd(0, 1, 12'h340, 32'h0, 12'h0, 32'h0);
    #1;
    n_tests++; if (bus.csr_rdata !== 32'h0) begin n_fail++; $display("FAIL mid_reset_write got %h exp 0", bus.csr_rdata); end
    n_tests++; if (mtvec !== 32'h8000_0000) begin n_fail++; $display("FAIL mid_reset_mtvec got %h exp %h", mtvec, 32'h8000_0000); end
  endtask

  initial begin
    test_reset();
    test_mtvec_write();
    test_mstatus_warl();
    test_ecall_mret();
    test_priority();
    test_collision();
    test_illegal();
    test_scratch_mepc();
    test_counters();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
